// File: rtl/up_counter_pkg.sv
// Shared types and helpers for the up/down counter family in the timing subsystem.
// Holds the run-FSM state encoding and the shift-left helper used by the datapaths.
package up_counter_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned MaxWidth     = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCount = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Shift left by one within the low `width` bits; optionally clamp to all-ones on MSB overflow.
    function automatic logic [MaxWidth-1:0] shift_left_sat(input logic [MaxWidth-1:0] value,
                                                           input int unsigned          width,
                                                           input bit                   saturate);
        logic [MaxWidth-1:0] mask;
        logic [MaxWidth-1:0] msb_vec;
        logic [MaxWidth-1:0] result;
        mask    = {MaxWidth{1'b1}} >> (MaxWidth - width);
        msb_vec = value >> (width - 1);
        if (saturate && msb_vec[0]) begin
            result = mask;
        end else begin
            result = (value << 1) & mask;
        end
        return result;
    endfunction

endpackage

// File: rtl/up_counter_fsm.sv
// Run-control FSM for up_counter: state register, terminal-value latch and busy/done generation.
// The done decision uses the pre-edge count so overriding load/shift cannot suppress it.
module up_counter_fsm
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] terminal_count_i,
    output logic [WIDTH-1:0] term_o,
    output logic             start_acc_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            term_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_d = StCount;
                        term_d  = terminal_count_i;
                    end
                end
                StCount: begin
                    if (count_i == term_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q == StCount);
        done_o      = done_q;
        term_o      = term_q;
        start_acc_o = start_i && !clear_i && ((state_q == StIdle) || (state_q == StDone));
    end

endmodule

// File: rtl/up_counter.sv
// Programmable up-counter/timer: counts from 0 (or a preload) up to a latched terminal value.
// Datapath lives here; run control is delegated to up_counter_fsm.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic             multiply_by_2,
    input  logic [WIDTH-1:0] preload_count,
    input  logic [WIDTH-1:0] terminal_count,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             full
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] shifted;
    logic             start_acc;

    up_counter_fsm #(
        .WIDTH (WIDTH)
    ) u_fsm (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .clear_i          (clear),
        .count_i          (count_q),
        .terminal_count_i (terminal_count),
        .term_o           (term_q),
        .start_acc_o      (start_acc),
        .busy_o           (busy),
        .done_o           (done)
    );

    assign shifted = WIDTH'(shift_left_sat(MaxWidth'(count_q), WIDTH, SATURATE));

    // Increment only below the terminal value: a count loaded above it stalls instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = preload_count;
        end else if (start_acc) begin
            count_d = '0;
        end else if (multiply_by_2) begin
            count_d = shifted;
        end else if (busy && enable && (count_q < term_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign full      = &count_q;

endmodule

// File: tb/tb_up_counter.sv
// Bench for up_counter: a saturating and a wrapping instance driven in lockstep and checked every
// cycle against an arithmetic reference model, with directed scenarios followed by random traffic.
module tb_up_counter;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, clear, enable, load, mul2;
    logic [W-1:0] pre, tc;

    logic [W-1:0] cnt_a, cnt_b;
    logic         busy_a, done_a, full_a, busy_b, done_b, full_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model; index 0 = saturating instance, 1 = wrapping instance.
    // Phase: 0 idle, 1 counting, 2 finished.
    int m_cnt [2];
    int m_ph  [2];
    int m_term[2];
    bit m_done[2];

    always #5 clk = ~clk;

    up_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .enable(enable), .load(load),
        .multiply_by_2(mul2), .preload_count(pre), .terminal_count(tc),
        .count_out(cnt_a), .busy(busy_a), .done(done_a), .full(full_a)
    );

    up_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .enable(enable), .load(load),
        .multiply_by_2(mul2), .preload_count(pre), .terminal_count(tc),
        .count_out(cnt_b), .busy(busy_b), .done(done_b), .full(full_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_ph[i]   = 0;
            m_term[i] = 0;
            m_done[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int c;
        int v;
        bit acc;
        bit fin;
        for (int i = 0; i < 2; i++) begin
            c = m_cnt[i];
            if (clear) begin
                m_cnt[i]  = 0;
                m_ph[i]   = 0;
                m_done[i] = 1'b0;
            end else begin
                acc = start && (m_ph[i] != 1);
                fin = (m_ph[i] == 1) && (c == m_term[i]);
                if (load) begin
                    m_cnt[i] = int'(pre);
                end else if (acc) begin
                    m_cnt[i] = 0;
                end else if (mul2) begin
                    v = c * 2;
                    if (v <= MAX) m_cnt[i] = v;
                    else          m_cnt[i] = (i == 0) ? MAX : v - (MAX + 1);
                end else if ((m_ph[i] == 1) && enable && (c < m_term[i])) begin
                    m_cnt[i] = c + 1;
                end
                if (acc) begin
                    m_ph[i]   = 1;
                    m_term[i] = int'(tc);
                end else if (fin) begin
                    m_ph[i] = 2;
                end
                m_done[i] = fin;
            end
        end
    endtask

    task automatic check_all();
        chk("cnt_sat",   32'(cnt_a),  32'(m_cnt[0]));
        chk("busy_sat",  32'(busy_a), 32'(m_ph[0] == 1));
        chk("done_sat",  32'(done_a), 32'(m_done[0]));
        chk("full_sat",  32'(full_a), 32'(m_cnt[0] == MAX));
        chk("cnt_wrap",  32'(cnt_b),  32'(m_cnt[1]));
        chk("busy_wrap", 32'(busy_b), 32'(m_ph[1] == 1));
        chk("done_wrap", 32'(done_b), 32'(m_done[1]));
        chk("full_wrap", 32'(full_b), 32'(m_cnt[1] == MAX));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        start  = 1'b0;
        clear  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        mul2   = 1'b0;
        pre    = '0;
        tc     = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic run to 3: done lands N+2 cycles after the start cycle.
        tc    = 8'd3;
        start = 1'b1;
        step();
        chk("basic_busy", 32'(busy_a), 32'd1);
        chk("basic_cnt0", 32'(cnt_a), 32'd0);
        start  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        chk("basic_cnt3", 32'(cnt_a), 32'd3);
        chk("basic_nodone", 32'(done_a), 32'd0);
        step();
        chk("basic_done", 32'(done_a), 32'd1);
        chk("basic_busy_low", 32'(busy_a), 32'd0);
        step();
        chk("basic_pulse", 32'(done_a), 32'd0);
        chk("basic_hold", 32'(cnt_a), 32'd3);

        // Enable gaps.
        tc    = 8'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            enable = (i % 2 == 0);
            step();
        end
        chk("gap_cnt4", 32'(cnt_a), 32'd4);
        enable = 1'b0;
        step();
        chk("gap_done", 32'(done_a), 32'd1);

        // Asynchronous reset mid-run at count 5.
        tc    = 8'd10;
        start = 1'b1;
        step();
        start  = 1'b0;
        enable = 1'b1;
        repeat (5) step();
        chk("rst_pre_cnt", 32'(cnt_a), 32'd5);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_async_cnt", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step();
        chk("rst_stay_idle", 32'(busy_a), 32'd0);

        // Shift with and without saturation.
        idle_inputs();
        load = 1'b1;
        pre  = 8'h90;
        step();
        load = 1'b0;
        mul2 = 1'b1;
        step();
        mul2 = 1'b0;
        chk("shift_sat", 32'(cnt_a), 32'hFF);
        chk("shift_sat_full", 32'(full_a), 32'd1);
        chk("shift_wrap", 32'(cnt_b), 32'h20);
        chk("shift_wrap_full", 32'(full_b), 32'd0);

        // Priority: clear beats load and start; load beats the start zeroing.
        tc    = 8'd9;
        start = 1'b1;
        step();
        start  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        clear = 1'b1;
        load  = 1'b1;
        start = 1'b1;
        pre   = 8'h44;
        step();
        chk("prio_clear_cnt", 32'(cnt_a), 32'd0);
        chk("prio_clear_busy", 32'(busy_a), 32'd0);
        chk("prio_clear_done", 32'(done_a), 32'd0);
        clear  = 1'b0;
        pre    = 8'h10;
        tc     = 8'h20;
        enable = 1'b0;
        step();
        chk("prio_load_cnt", 32'(cnt_a), 32'h10);
        chk("prio_load_busy", 32'(busy_a), 32'd1);
        load   = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
        repeat (17) step();
        chk("prio_run_done", 32'(done_a), 32'd1);

        // Restart from DONE with terminal value 0.
        idle_inputs();
        start = 1'b1;
        step();
        chk("t0_busy", 32'(busy_a), 32'd1);
        start = 1'b0;
        step();
        chk("t0_done", 32'(done_a), 32'd1);
        chk("t0_cnt", 32'(cnt_a), 32'd0);

        // Terminal value is latched: changing it mid-run has no effect.
        tc    = 8'd6;
        start = 1'b1;
        step();
        start  = 1'b0;
        enable = 1'b1;
        tc     = 8'd1;
        repeat (6) step();
        chk("latch_cnt6", 32'(cnt_a), 32'd6);
        chk("latch_nodone", 32'(done_a), 32'd0);
        step();
        chk("latch_done", 32'(done_a), 32'd1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            start  = ($urandom_range(0, 7) == 0);
            clear  = ($urandom_range(0, 31) == 0);
            load   = ($urandom_range(0, 15) == 0);
            mul2   = ($urandom_range(0, 15) == 0);
            enable = ($urandom_range(0, 3) != 0);
            pre    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            tc     = 8'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
